button_input: RTL and testbench

- Player-side front end for the game controller's button interface: the producer of the IN / IN_VALID pair and of START_GAME.
- Takes four raw asynchronous colour buttons and one raw start button.
- Synchronises and debounces them and encodes a single held colour button as a 2-bit code.
- Holds IN_VALID high for exactly the debounced duration of the press; rejects multi-button presses.

---
 rtl/button_input.sv | 183 ++++++++++++++++++
 tb/tb_button_input.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_input.sv
// Player-side button front end: synchronises and debounces four colour buttons and
// a start button, and presents a single held colour as IN/IN_VALID plus START_GAME.
//
// state         | meaning
// --------------+------------------------------------------------------------
// S_IDLE        | no colour accepted; waiting for exactly one button
// S_DEB_PRESS   | one button seen; counting stable cycles before accepting it
// S_HELD        | press accepted; IN/IN_VALID presented
// S_DEB_RELEASE | captured button dropped; waiting for all buttons stable low
module button_input #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       BTN_START,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       START_GAME,
  output logic       MULTI_ERR
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_HELD,
    S_DEB_RELEASE
  } state_t;

  logic [4:0] sync1_q, sync2_q;
  logic [3:0] s_btn;
  logic       s_start;

  state_t           state_q, state_d;
  logic [1:0]       cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       in_q, in_d;
  logic             valid_q, valid_d;
  logic             multi_prev_q, multi_prev_d;
  logic             merr_q, merr_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             start_q, start_d;

  logic       is_onehot, is_multi;
  logic [1:0] enc;
  logic [3:0] cap_mask;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {BTN_START, BTN};
      sync2_q <= sync1_q;
    end
  end

  assign s_btn   = sync2_q[3:0];
  assign s_start = sync2_q[4];

  assign is_onehot = (s_btn != 4'd0) && ((s_btn & (s_btn - 4'd1)) == 4'd0);
  assign is_multi  = (s_btn != 4'd0) && !is_onehot;
  assign cap_mask  = 4'b0001 << cap_q;

  always_comb begin
    enc = 2'd0;
    case (s_btn)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      cap_q        <= 2'd0;
      cnt_q        <= '0;
      in_q         <= 2'd0;
      valid_q      <= 1'b0;
      multi_prev_q <= 1'b0;
      merr_q       <= 1'b0;
      scnt_q       <= '0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      cnt_q        <= cnt_d;
      in_q         <= in_d;
      valid_q      <= valid_d;
      multi_prev_q <= multi_prev_d;
      merr_q       <= merr_d;
      scnt_q       <= scnt_d;
      start_q      <= start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    cnt_d        = cnt_q;
    in_d         = in_q;
    valid_d      = valid_q;
    merr_d       = 1'b0;
    multi_prev_d = is_multi;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (is_onehot) begin
          cap_d   = enc;
          cnt_d   = '0;
          state_d = S_DEB_PRESS;
        end else if (is_multi && !multi_prev_q) begin
          // only the transition into a multi-press is flagged, not the hold
          merr_d = 1'b1;
        end
      end
      S_DEB_PRESS: begin
        if (s_btn != cap_mask) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_TC) begin
          state_d = S_HELD;
          in_d    = cap_q;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!s_btn[cap_q]) begin
          state_d = S_DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      S_DEB_RELEASE: begin
        // every button must be stably low before the next press is accepted
        if (s_btn[cap_q]) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (s_btn != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    scnt_d  = scnt_q;
    start_d = start_q;
    if (s_start == start_q) begin
      scnt_d = '0;
    end else if (scnt_q == CNT_TC) begin
      start_d = s_start;
      scnt_d  = '0;
    end else begin
      scnt_d = scnt_q + CNT_ONE;
    end
  end

  assign IN         = in_q;
  assign IN_VALID   = valid_q;
  assign START_GAME = start_q;
  assign MULTI_ERR  = merr_q;

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input: expected output events (edge kind, cycle, code)
// are queued as stimulus is driven and matched as the monitor sees them.
module tb_button_input;

  localparam int D    = 4;
  localparam int LAT  = D + 3;
  localparam int SLAT = D + 2;

  localparam int EV_RISE   = 0;
  localparam int EV_FALL   = 1;
  localparam int EV_MULTI  = 2;
  localparam int EV_SRISE  = 3;
  localparam int EV_SFALL  = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] BTN = 4'd0;
  logic       BTN_START = 1'b0;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       START_GAME;
  logic       MULTI_ERR;

  typedef struct {
    int kind;
    int cyc;
    int code;
  } ev_t;

  ev_t q_col[$];
  ev_t q_start[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int cur_code = 0;

  button_input #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN        (BTN),
    .BTN_START  (BTN_START),
    .IN         (IN),
    .IN_VALID   (IN_VALID),
    .START_GAME (START_GAME),
    .MULTI_ERR  (MULTI_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic void exp_col(input int kind, input int c, input int code);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.code = code;
    q_col.push_back(e);
  endfunction

  function automatic void exp_start(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.code = 0;
    q_start.push_back(e);
  endfunction

  task automatic drive(input logic [3:0] v, output int t);
    @(negedge CLK);
    BTN = v;
    t = cyc;
  endtask

  task automatic drive_start(input logic v, output int t);
    @(negedge CLK);
    BTN_START = v;
    t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in"},       int'(IN),         0);
    chk({tag, "_valid"},    int'(IN_VALID),   0);
    chk({tag, "_start"},    int'(START_GAME), 0);
    chk({tag, "_multi"},    int'(MULTI_ERR),  0);
  endtask

  // monitor: every output event must match the head of its queue
  initial begin : monitor
    logic pv, ps;
    ev_t  e;
    pv = 1'b0;
    ps = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        pv = 1'b0;
        ps = 1'b0;
      end else begin
        if (IN_VALID !== pv) begin
          if (q_col.size() == 0) begin
            chk("unexp_valid_edge", int'(IN_VALID), int'(pv));
          end else begin
            e = q_col.pop_front();
            chk("valid_edge_kind", IN_VALID ? EV_RISE : EV_FALL, e.kind);
            chk("valid_edge_cyc", cyc, e.cyc);
            cur_code = e.code;
          end
          pv = IN_VALID;
        end
        if (IN_VALID) chk("in_code", int'(IN), cur_code);
        if (MULTI_ERR) begin
          if (q_col.size() == 0) begin
            chk("unexp_multi", int'(MULTI_ERR), 0);
          end else begin
            e = q_col.pop_front();
            chk("multi_kind", EV_MULTI, e.kind);
            chk("multi_cyc", cyc, e.cyc);
          end
        end
        if (START_GAME !== ps) begin
          if (q_start.size() == 0) begin
            chk("unexp_start_edge", int'(START_GAME), int'(ps));
          end else begin
            e = q_start.pop_front();
            chk("start_edge_kind", START_GAME ? EV_SRISE : EV_SFALL, e.kind);
            chk("start_edge_cyc", cyc, e.cyc);
          end
          ps = START_GAME;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: stimulus did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    RST_N = 1'b0;
    idle(3);
    chk_outputs_zero("por");
    @(negedge CLK);
    RST_N = 1'b1;
    idle(3);

    // clean press and release of colour 2
    drive(4'b0100, t);
    exp_col(EV_RISE, t + LAT, 2);
    idle(20);
    drive(4'b0000, t);
    exp_col(EV_FALL, t + LAT, 2);
    idle(12);

    // press bounce on colour 1; only the final stable rise counts
    drive(4'b0010, t);
    drive(4'b0000, t);
    drive(4'b0010, t);
    drive(4'b0000, t);
    drive(4'b0010, t);
    exp_col(EV_RISE, t + LAT, 1);
    idle(12);
    drive(4'b0000, t);
    exp_col(EV_FALL, t + LAT, 1);
    idle(12);

    // two buttons together: one error pulse, no press
    drive(4'b0011, t);
    exp_col(EV_MULTI, t + 3, 0);
    idle(9);
    drive(4'b0000, t);
    idle(10);
    drive(4'b1000, t);
    exp_col(EV_RISE, t + LAT, 3);
    idle(12);

    // release bounce on colour 3: low 2 cycles, high 1, then low
    drive(4'b0000, t);
    drive(4'b0000, t);
    drive(4'b1000, t);
    drive(4'b0000, t);
    exp_col(EV_FALL, t + LAT, 3);
    idle(12);

    // second button joins a held press while the start button runs concurrently
    fork
      begin : col_branch
        int tc;
        drive(4'b0001, tc);
        exp_col(EV_RISE, tc + LAT, 0);
        idle(10);
        drive(4'b0101, tc);
        idle(3);
        drive(4'b0100, tc);
        idle(9);
        drive(4'b0000, tc);
        // already in release debounce with the count held at zero
        exp_col(EV_FALL, tc + D + 2, 0);
        idle(12);
      end
      begin : start_branch
        int ts;
        idle(2);
        drive_start(1'b1, ts);
        exp_start(EV_SRISE, ts + SLAT);
        idle(9);
        drive_start(1'b0, ts);
        exp_start(EV_SFALL, ts + SLAT);
        idle(10);
      end
    join

    // asynchronous reset while held; the still-held button is a fresh press
    drive(4'b0010, t);
    exp_col(EV_RISE, t + LAT, 1);
    idle(10);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    t = cyc;
    exp_col(EV_RISE, t + LAT, 1);
    idle(12);
    drive(4'b0000, t);
    exp_col(EV_FALL, t + LAT, 1);
    idle(15);

    chk("col_events_left", q_col.size(), 0);
    chk("start_events_left", q_start.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
